// File: rtl/pool_stride_select.sv
// Keeps only stride-aligned, fully-inside pool windows from the max-pool stream
// and writes them to the next layer's input buffer, pulsing start once per frame.

module pool_stride_lane #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
    end
endmodule

module pool_stride_select #(
    parameter int DATA_SIZE  = 8,
    parameter int CHANNELS   = 256,
    parameter int IMG_DIM    = 13,
    parameter int KERNEL_DIM = 3,
    parameter int STRIDE     = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CHANNELS-1:0]                i_we,
    input  logic [CHANNELS-1:0][DATA_SIZE-1:0] i_data,
    input  logic                               i_start,
    output logic                               o_ready,
    input  logic                               i_next_ready,
    output logic [CHANNELS-1:0][DATA_SIZE-1:0] o_next_data,
    output logic [CHANNELS-1:0]                o_next_we,
    output logic                               o_next_start
);
    localparam int CW      = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1;
    localparam int PW      = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int OUT_DIM = (IMG_DIM - KERNEL_DIM) / STRIDE + 1;

    localparam logic [CW-1:0] LAST = CW'(IMG_DIM - 1);
    localparam logic [CW-1:0] KM1  = CW'(KERNEL_DIM - 1);
    localparam logic [CW-1:0] BND  = CW'((OUT_DIM - 1) * STRIDE + KERNEL_DIM - 1);
    localparam logic [PW-1:0] SM1  = PW'(STRIDE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] row, col;
    logic [PW-1:0] rph, cph;
    logic          pend, we_q;
    logic          strobe, last_px, sel;

    assign strobe  = |i_we;
    assign last_px = pend && (row == LAST) && (col == LAST);
    assign sel     = pend && (row >= KM1) && (col >= KM1) && (rph == '0) && (cph == '0)
                     && (row <= BND) && (col <= BND);

    assign o_ready      = i_next_ready && (state == IDLE);
    assign o_next_start = (state == DONE);
    assign o_next_we    = {CHANNELS{we_q}};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_start && o_ready) state_nx = RUN;
            RUN:     if (last_px) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Pending flag delays sampling one cycle so the pool FIFO has shifted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
            we_q <= 1'b0;
        end else begin
            pend <= strobe && (state == RUN) && (state_nx == RUN);
            we_q <= sel;
        end
    end

    // Phase counters stay at 0 until the window first fits, then cycle through the stride.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
            rph <= '0;
            cph <= '0;
        end else if (state == IDLE && state_nx == RUN) begin
            row <= '0;
            col <= '0;
            rph <= '0;
            cph <= '0;
        end else if (state == RUN && pend) begin
            if (col == LAST) begin
                col <= '0;
                cph <= '0;
                row <= row + CW'(1);
                if (row >= KM1) rph <= (rph == SM1) ? '0 : rph + PW'(1);
                else            rph <= '0;
            end else begin
                col <= col + CW'(1);
                if (col >= KM1) cph <= (cph == SM1) ? '0 : cph + PW'(1);
                else            cph <= '0;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        pool_stride_lane #(.W(DATA_SIZE)) u_lane (
            .clk (clk),
            .rst (rst),
            .en  (sel),
            .d   (i_data[g]),
            .q   (o_next_data[g])
        );
    end
endmodule

// File: tb/tb_pool_stride_select.sv
// Scoreboard bench: small-image instance for directed/random/handshake/reset cases,
// default-geometry instance for the 13x13 frame.

module tb_pool_stride_select;
    localparam int DS = 8;
    localparam int CS = 2, IS = 5,  KS = 2, SS = 2;
    localparam int CB = 4, IB = 13, KB = 3, SB = 2;

    typedef struct { int data; int cyc; } exp_t;

    logic clk = 1'b0, rst = 1'b1;
    int   cyc = 0;
    int   errors = 0, checks = 0;

    logic [CS-1:0]        s_we = '0, s_nwe;
    logic [CS-1:0][DS-1:0] s_data = '0, s_ndata;
    logic s_start = 1'b0, s_nr = 1'b1, s_ready, s_nstart;
    logic [CB-1:0]        b_we = '0, b_nwe;
    logic [CB-1:0][DS-1:0] b_data = '0, b_ndata;
    logic b_start = 1'b0, b_nr = 1'b1, b_ready, b_nstart;

    exp_t qs[$], qb[$];
    int   ss[$], sb[$];
    bit   s_prev = 0, b_prev = 0;
    int   s_prevp = 0, b_prevp = 0;

    pool_stride_select #(.DATA_SIZE(DS), .CHANNELS(CS), .IMG_DIM(IS), .KERNEL_DIM(KS), .STRIDE(SS)) u_s (
        .clk(clk), .rst(rst), .i_we(s_we), .i_data(s_data), .i_start(s_start), .o_ready(s_ready),
        .i_next_ready(s_nr), .o_next_data(s_ndata), .o_next_we(s_nwe), .o_next_start(s_nstart));

    pool_stride_select #(.DATA_SIZE(DS), .CHANNELS(CB)) u_b (
        .clk(clk), .rst(rst), .i_we(b_we), .i_data(b_data), .i_start(b_start), .o_ready(b_ready),
        .i_next_ready(b_nr), .o_next_data(b_ndata), .o_next_we(b_nwe), .o_next_start(b_nstart));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference selection rule: window fully inside the image and on the stride grid.
    function automatic bit model_sel(input int p, input int img, input int k, input int s);
        int r, c, od, bnd;
        r = p / img;
        c = p % img;
        od = (img - k) / s + 1;
        bnd = (od - 1) * s + k - 1;
        return r >= k - 1 && c >= k - 1 && (r - k + 1) % s == 0 && (c - k + 1) % s == 0
               && r <= bnd && c <= bnd;
    endfunction

    // One clock of stimulus; i_data shows the pixel strobed in the previous cycle.
    task automatic step(input bit big, input bit stb, input int p, input bit st);
        @(posedge clk); #1;
        if (big) begin
            if (b_prev) for (int i = 0; i < CB; i++) b_data[i] = DS'(b_prevp);
            b_we = stb ? '1 : '0;
            b_start = st;
            b_prev = stb;
            b_prevp = p;
        end else begin
            if (s_prev) for (int i = 0; i < CS; i++) s_data[i] = DS'(s_prevp);
            s_we = stb ? '1 : '0;
            s_start = st;
            s_prev = stb;
            s_prevp = p;
        end
    endtask

    task automatic frame(input bit big, input int maxgap, input int npix, input bit stray);
        int img, k, s;
        img = big ? IB : IS;
        k = big ? KB : KS;
        s = big ? SB : SS;
        step(big, 0, 0, 1);
        for (int p = 0; p < npix; p++) begin
            int gap;
            gap = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
            for (int g = 0; g < gap; g++) step(big, 0, 0, 0);
            step(big, 1, p, stray && p == 12);
            if (model_sel(p, img, k, s)) begin
                if (big) qb.push_back('{p % 256, cyc + 2});
                else     qs.push_back('{p, cyc + 2});
            end
            if (p == img * img - 1) begin
                if (big) sb.push_back(cyc + 2);
                else     ss.push_back(cyc + 2);
            end
        end
        for (int i = 0; i < 4; i++) step(big, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (s_nwe != '0) begin
                chk("s_we_all_bits", int'(s_nwe), (1 << CS) - 1);
                chk("s_we_expected", int'(qs.size() > 0), 1);
                if (qs.size() > 0) begin
                    exp_t e;
                    e = qs.pop_front();
                    chk("s_we_cycle", cyc, e.cyc);
                    for (int i = 0; i < CS; i++) chk("s_data", int'(s_ndata[i]), e.data);
                end
            end
            if (s_nstart) begin
                chk("s_start_expected", int'(ss.size() > 0), 1);
                if (ss.size() > 0) chk("s_start_cycle", cyc, ss.pop_front());
            end
            if (b_nwe != '0) begin
                chk("b_we_all_bits", int'(b_nwe), (1 << CB) - 1);
                chk("b_we_expected", int'(qb.size() > 0), 1);
                if (qb.size() > 0) begin
                    exp_t e;
                    e = qb.pop_front();
                    chk("b_we_cycle", cyc, e.cyc);
                    for (int i = 0; i < CB; i++) chk("b_data", int'(b_ndata[i]), e.data);
                end
            end
            if (b_nstart) begin
                chk("b_start_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) chk("b_start_cycle", cyc, sb.pop_front());
            end
        end
    end

    initial begin
        #1;
        chk("rst_we", int'(s_nwe), 0);
        chk("rst_data", int'(s_ndata), 0);
        chk("rst_start", int'(s_nstart), 0);
        chk("rst_ready", int'(s_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // strobes before any start are ignored
        for (int i = 0; i < 3; i++) step(0, 1, 99, 0);
        step(0, 0, 0, 0);

        frame(0, 0, IS * IS, 0);   // directed back-to-back
        frame(0, 0, IS * IS, 1);   // start during RUN ignored, identical output
        frame(0, 3, IS * IS, 0);   // random gaps

        // next layer not ready: start ignored, strobes do nothing
        s_nr = 1'b0;
        step(0, 0, 0, 1);
        #1 chk("nr_ready_low", int'(s_ready), 0);
        for (int i = 0; i < 6; i++) step(0, 1, 50 + i, 0);
        step(0, 0, 0, 0);
        s_nr = 1'b1;
        #1 chk("nr_ready_back", int'(s_ready), 1);
        frame(0, 0, IS * IS, 0);

        // reset mid-frame after strobe 10
        frame(0, 0, 11, 0);
        #1 rst = 1'b1;
        s_prev = 0;
        #1;
        chk("mid_rst_we", int'(s_nwe), 0);
        chk("mid_rst_data", int'(s_ndata), 0);
        chk("mid_rst_start", int'(s_nstart), 0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 1, 77, 0);
        step(0, 0, 0, 0);
        frame(0, 2, IS * IS, 0);

        frame(1, 0, IB * IB, 0);   // default geometry
        frame(1, 1, IB * IB, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("s_pending_writes", qs.size(), 0);
        chk("s_pending_starts", ss.size(), 0);
        chk("b_pending_writes", qb.size(), 0);
        chk("b_pending_starts", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
